wb_daq_sram_writer: RTL and testbench
=====================================

Name: wb_daq_sram_writer

Overview:
- Responder end of the channel-to-SRAM request handshake.
- Each DAQ channel raises start_sram with one 32-bit word held on its data bus. This block arbitrates round-robin among channels, returns a one-cycle grant, and writes the word to SRAM as a single Wishbone master write.
- Each channel owns a circular buffer region in SRAM. Per-channel write pointers and wrap flags are exported for the register file.

Parameters:
- dw, 32, data width of channel words and Wishbone data bus.
- aw, 32, Wishbone address width.
- num_ch, 4, number of DAQ channels (1..8).
- region_aw, 8, log2 of words per channel region (256 words).
- base_addr, 32'h0000_0000, byte base address of channel 0 region; aligned to num_ch*4*2^region_aw.

Ports:
- wb_clk  input  1  system clock
- wb_rst  input  1  asynchronous active-high reset
- enable  input  1  master enable; low blocks new grants
- clear  input  1  synchronous: zero all pointers and wrap flags
- start_sram  input  num_ch  per-channel write request
- data_in  input  num_ch*dw  channel c word on bits [c*dw +: dw]
- grant  output  num_ch  one-hot, one-cycle acceptance pulse
- wb_adr_o  output  aw  Wishbone address
- wb_dat_o  output  dw  Wishbone write data
- wb_sel_o  output  4  byte selects, always 4'hF during a cycle
- wb_we_o  output  1  write enable
- wb_cyc_o  output  1  cycle
- wb_stb_o  output  1  strobe
- wb_ack_i  input  1  acknowledge
- wb_err_i  input  1  bus error
- wr_ptr  output  num_ch*region_aw  next word index per channel
- wrapped  output  num_ch  sticky: channel pointer has wrapped
- bus_error  output  1  sticky: any wb_err_i seen

Behaviour:
- Reset (async, wb_rst=1): all outputs 0; state IDLE; pointers 0; round-robin last = num_ch-1. wb_sel_o is 0 outside a cycle.
- State IDLE:
  - If enable and any start_sram bit is set, select the first requesting channel searching from last+1 upward with modulo wrap.
  - On that edge register: grant one-hot (high exactly one cycle); latch data_in slice into wb_dat_o; wb_adr_o = base_addr + {c, wr_ptr[c], 2'b00}; cyc=stb=we=1, sel=4'hF; last=c; go WRITE.
  - Grant and first stb cycle coincide. Request-to-grant latency is 1 cycle.
- State WRITE:
  - Hold all bus outputs stable until wb_ack_i or wb_err_i.
  - On ack: drop cyc/stb/we/sel; wr_ptr[c] += 1 modulo 2^region_aw; on wrap from all-ones to 0 set wrapped[c]; go IDLE.
  - On err (err takes priority over simultaneous ack): drop cycle; set bus_error; pointer unchanged; go IDLE.
- IDLE lasts at least one cycle between writes. This guarantees a channel has deasserted start_sram after its grant.
- Channel contract: hold start_sram and data stable until grant is seen; deassert start_sram on the cycle following grant. The block does not re-grant a channel within the same transaction.
- enable low: no new grants. A write in progress completes normally. Pending requests remain pending.
- clear:
  - In IDLE: zeroes wr_ptr, wrapped and bus_error.
  - During WRITE: applied immediately, and the completing ack then increments the cleared pointer to 1.
- Single requester: that channel is granted back-to-back with no starvation of others, since round-robin rotates past it whenever others request.
- No wait-state limit; a stalled slave stalls the block indefinitely. A timeout is out of scope.

Test Plan:
- Reset/idle: assert wb_rst mid-WRITE (cyc=1) -> cyc, stb, grant and wr_ptr go 0 immediately without a clock edge; after release, no bus activity with start_sram=0.
- Single write: ch1 requests with data 32'hA5A5_0001, slave acks 2 cycles later -> grant=4'b0010 for 1 cycle; wb_adr_o=32'h0000_0400, wb_dat_o=A5A5_0001, sel=F, we=1; wr_ptr[1]=1.
- Round-robin: all 4 channels request continuously (re-raising after each grant), ack immediate -> grant order ch0,ch1,ch2,ch3,ch0; each channel gets one grant per 4 writes.
- Wrap: preload by 256 writes on ch2 -> addresses 0x800..0xBFC, then the 257th goes to 0x800; wrapped=4'b0100, wr_ptr[2]=1.
- Error: slave returns wb_err_i together with wb_ack_i on a ch3 write -> bus_error=1, wr_ptr[3] unchanged, next request still served.
- Enable gating: enable=0 with ch0 requesting for 10 cycles -> no grant, cyc=0; enable=1 -> grant on next cycle.

Source files
------------

// File: rtl/wb_daq_sram_writer_if.sv
// Wishbone write-master bus bundle between the DAQ SRAM writer and the SRAM slave.
interface wb_daq_sram_writer_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_daq_sram_writer.sv
// Round-robin arbiter that turns one-word DAQ channel requests into single Wishbone
// writes into per-channel circular SRAM regions, tracking write pointers and wraps.
module wb_daq_sram_writer #(
  parameter int              dw        = 32,
  parameter int              aw        = 32,
  parameter int              num_ch    = 4,
  parameter int              region_aw = 8,
  parameter logic [aw-1:0]   base_addr = '0
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [num_ch-1:0]           start_sram,
  input  logic [num_ch*dw-1:0]        data_in,
  output logic [num_ch-1:0]           grant,
  wb_daq_sram_writer_if.master        wb,
  output logic [num_ch*region_aw-1:0] wr_ptr,
  output logic [num_ch-1:0]           wrapped,
  output logic                        bus_error
);

  localparam int CW = (num_ch > 1) ? $clog2(num_ch) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t               state_q, state_d;
  logic [num_ch-1:0]    grant_q, grant_d;
  logic [num_ch-1:0]    wrapped_q, wrapped_d;
  logic [CW-1:0]        last_q, last_d;
  logic [aw-1:0]        adr_q, adr_d;
  logic [dw-1:0]        dat_q, dat_d;
  logic                 cyc_q, cyc_d;
  logic                 berr_q, berr_d;
  logic [region_aw-1:0] ptr_q [num_ch];
  logic [region_aw-1:0] ptr_d [num_ch];

  // Round-robin pick: first requester strictly after the last granted channel.
  logic          sel_vld;
  logic [CW-1:0] sel_ch;
  logic [CW:0]   sum;

  always_comb begin
    sel_vld = 1'b0;
    sel_ch  = last_q;
    sum     = '0;
    for (int i = 1; i <= num_ch; i++) begin
      sum = {1'b0, last_q} + (CW+1)'(i);
      if (sum >= (CW+1)'(num_ch)) sum = sum - (CW+1)'(num_ch);
      if (!sel_vld && start_sram[sum[CW-1:0]]) begin
        sel_vld = 1'b1;
        sel_ch  = sum[CW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    last_d    = last_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cyc_d     = cyc_q;
    berr_d    = berr_q & ~clear;
    wrapped_d = clear ? '0 : wrapped_q;
    for (int c = 0; c < num_ch; c++) ptr_d[c] = clear ? '0 : ptr_q[c];

    case (state_q)
      IDLE: begin
        if (enable && sel_vld) begin
          grant_d[sel_ch] = 1'b1;
          dat_d   = data_in[int'(sel_ch)*dw +: dw];
          adr_d   = base_addr + (aw'(sel_ch) << (region_aw + 2)) + (aw'(ptr_d[sel_ch]) << 2);
          cyc_d   = 1'b1;
          last_d  = sel_ch;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Error wins over a simultaneous ack and leaves the pointer untouched.
        if (wb.wb_err_i) begin
          cyc_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (ptr_d[last_q] == '1) wrapped_d[last_q] = 1'b1;
          ptr_d[last_q] = ptr_d[last_q] + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      wrapped_q <= '0;
      last_q    <= CW'(num_ch - 1);
      adr_q     <= '0;
      dat_q     <= '0;
      cyc_q     <= 1'b0;
      berr_q    <= 1'b0;
      for (int c = 0; c < num_ch; c++) ptr_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wrapped_q <= wrapped_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cyc_q     <= cyc_d;
      berr_q    <= berr_d;
      for (int c = 0; c < num_ch; c++) ptr_q[c] <= ptr_d[c];
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = {4{cyc_q}};
  assign wb.wb_we_o  = cyc_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign grant       = grant_q;
  assign wrapped     = wrapped_q;
  assign bus_error   = berr_q;

  for (genvar c = 0; c < num_ch; c++) begin : g_ptr
    assign wr_ptr[c*region_aw +: region_aw] = ptr_q[c];
  end

endmodule

// File: tb/tb_wb_daq_sram_writer.sv
// Directed bench for wb_daq_sram_writer: scoreboarded writes, round-robin, wrap, error, enable, clear, reset.
module tb_wb_daq_sram_writer;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RAW = 8;

  logic                 wb_clk = 1'b0;
  logic                 wb_rst = 1'b1;
  logic                 enable = 1'b0;
  logic                 clear  = 1'b0;
  logic [NCH-1:0]       start_sram = '0;
  logic [NCH*DW-1:0]    data_in = '0;
  logic [NCH-1:0]       grant;
  logic [NCH*RAW-1:0]   wr_ptr;
  logic [NCH-1:0]       wrapped;
  logic                 bus_error;

  wb_daq_sram_writer_if #(.dw(DW), .aw(AW)) bus ();

  wb_daq_sram_writer #(
    .dw(DW), .aw(AW), .num_ch(NCH), .region_aw(RAW), .base_addr(32'h0000_0000)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .enable     (enable),
    .clear      (clear),
    .start_sram (start_sram),
    .data_in    (data_in),
    .grant      (grant),
    .wb         (bus),
    .wr_ptr     (wr_ptr),
    .wrapped    (wrapped),
    .bus_error  (bus_error)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t           sb[$];
  int             npass  = 0;
  int             ntotal = 0;
  int             mdl_ptr [NCH];
  logic [NCH-1:0] mdl_wrap = '0;
  logic           mdl_berr = 1'b0;
  int             lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NCH*RAW-1:0] mdl_ptr_vec();
    logic [NCH*RAW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*RAW +: RAW] = RAW'(mdl_ptr[c]);
    return v;
  endfunction

  task automatic mdl_clear();
    for (int c = 0; c < NCH; c++) mdl_ptr[c] = 0;
    mdl_wrap = '0;
    mdl_berr = 1'b0;
  endtask

  // Raise a channel request and record the write it should produce.
  task automatic push(input int ch, input logic [31:0] d);
    exp_t e;
    start_sram[ch]        = 1'b1;
    data_in[ch*DW +: DW]  = d;
    e.ch  = 2'(ch);
    e.adr = 32'(ch * 1024 + mdl_ptr[ch] * 4);
    e.dat = d;
    sb.push_back(e);
  endtask

  // Wait for a grant, check the bus cycle, respond after dly cycles, check the aftermath.
  task automatic serve(input int dly, input bit err, input bit rearm, input bit clr, output int latency);
    exp_t e;
    int   ch;
    bit   got;
    got = 1'b0;
    latency = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge wb_clk);
      latency++;
      if (grant != '0) got = 1'b1;
    end
    if (!got) begin
      ntotal++;
      $error("FAIL grant_timeout: observed no grant within 40 cycles, expected one");
      return;
    end
    if (sb.size() == 0) begin
      ntotal++;
      $error("FAIL sb_empty: observed grant %b, expected no grant", grant);
      bus.wb_ack_i = 1'b1;
      @(negedge wb_clk);
      bus.wb_ack_i = 1'b0;
      return;
    end
    e  = sb.pop_front();
    ch = int'(e.ch);
    check("grant", 64'(grant), 64'(1 << ch));
    check("adr", 64'(bus.wb_adr_o), 64'(e.adr));
    check("dat", 64'(bus.wb_dat_o), 64'(e.dat));
    check("sel", 64'(bus.wb_sel_o), 64'(4'hF));
    check("we_stb_cyc", 64'({bus.wb_we_o, bus.wb_stb_o, bus.wb_cyc_o}), 64'(3'b111));
    start_sram[ch] = 1'b0;
    for (int d = 0; d < dly; d++) begin
      if (clr && d == 0) clear = 1'b1;
      @(negedge wb_clk);
      if (clear) begin
        clear = 1'b0;
        mdl_clear();
      end
      check("hold_adr", 64'(bus.wb_adr_o), 64'(e.adr));
      check("hold_cyc", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'(2'b11));
      check("grant_pulse", 64'(grant), 64'(0));
    end
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = err;
    @(negedge wb_clk);
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    if (err) mdl_berr = 1'b1;
    else begin
      if (mdl_ptr[ch] == 255) mdl_wrap[ch] = 1'b1;
      mdl_ptr[ch] = (mdl_ptr[ch] + 1) % 256;
    end
    check("cyc_drop", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 64'(0));
    check("sel_drop", 64'(bus.wb_sel_o), 64'(0));
    check("wr_ptr", 64'(wr_ptr), 64'(mdl_ptr_vec()));
    check("wrapped", 64'(wrapped), 64'(mdl_wrap));
    check("bus_error", 64'(bus_error), 64'(mdl_berr));
    if (rearm) push(ch, 32'hC0DE_0000 | 32'(ch << 8) | 32'(mdl_ptr[ch]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    mdl_clear();

    // Reset state
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("rst_cyc", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 64'(0));
    check("rst_sel", 64'(bus.wb_sel_o), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_ptr", 64'(wr_ptr), 64'(0));
    check("rst_flags", 64'({wrapped, bus_error}), 64'(0));
    wb_rst = 1'b0;
    enable = 1'b1;
    @(negedge wb_clk);

    // Single write on ch1, slave acks two cycles later
    push(1, 32'hA5A5_0001);
    check("single_adr_model", 64'(sb[0].adr), 64'(32'h0000_0400));
    serve(2, 1'b0, 1'b0, 1'b0, lat);
    check("single_latency", 64'(lat), 64'(1));

    // Asynchronous reset in the middle of a write
    push(1, 32'h1234_5678);
    for (int i = 0; i < 10 && grant == '0; i++) @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    check("arst_cyc_stb", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'(0));
    check("arst_grant", 64'(grant), 64'(0));
    check("arst_ptr", 64'(wr_ptr), 64'(0));
    sb.delete();
    start_sram = '0;
    mdl_clear();
    @(negedge wb_clk);
    wb_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk);
      check("idle_no_cyc", 64'({bus.wb_cyc_o, grant}), 64'(0));
    end

    // Round-robin with all channels re-requesting
    for (int c = 0; c < NCH; c++) push(c, 32'hD000_0000 | 32'(c));
    for (int k = 0; k < 8; k++) serve(0, 1'b0, k < 4, 1'b0, lat);

    // Clear in IDLE, then wrap ch2
    clear = 1'b1;
    @(negedge wb_clk);
    clear = 1'b0;
    mdl_clear();
    check("clear_ptr", 64'(wr_ptr), 64'(0));
    check("clear_wrap", 64'(wrapped), 64'(0));
    for (int i = 0; i < 257; i++) begin
      push(2, 32'hBEEF_0000 + 32'(i));
      if (i == 256) check("wrap_adr_model", 64'(sb[0].adr), 64'(32'h0000_0800));
      serve(0, 1'b0, 1'b0, 1'b0, lat);
      if (i == 254) check("pre_wrap", 64'(wrapped), 64'(0));
    end
    check("wrap_flag", 64'(wrapped), 64'(4'b0100));
    check("wrap_ptr2", 64'(wr_ptr[2*RAW +: RAW]), 64'(1));

    // Error with simultaneous ack on ch3, then a normal retry
    push(3, 32'hEEEE_0003);
    serve(0, 1'b1, 1'b0, 1'b0, lat);
    check("err_ptr3", 64'(wr_ptr[3*RAW +: RAW]), 64'(0));
    check("err_flag", 64'(bus_error), 64'(1));
    push(3, 32'h0000_3333);
    serve(1, 1'b0, 1'b0, 1'b0, lat);

    // Clear while a write is in flight
    push(0, 32'h0A0A_0A0A);
    serve(0, 1'b0, 1'b0, 1'b0, lat);
    push(0, 32'h0B0B_0B0B);
    serve(3, 1'b0, 1'b0, 1'b1, lat);
    check("clr_write_ptr0", 64'(wr_ptr[RAW-1:0]), 64'(1));

    // Enable gating
    enable = 1'b0;
    push(0, 32'h5555_AAAA);
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      check("gated", 64'({grant, bus.wb_cyc_o}), 64'(0));
    end
    enable = 1'b1;
    serve(0, 1'b0, 1'b0, 1'b0, lat);
    check("enable_latency", 64'(lat), 64'(1));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
